// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// The source drives operands and consumes results (master);
// the ALU accepts operands and presents results (slave).
interface alu_pipe_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         op;
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] out;
    logic               zero;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output A, B, op, in_valid, out_ready,
        input  in_ready, out, zero, out_valid
    );

    modport slave (
        input  A, B, op, in_valid, out_ready,
        output in_ready, out, zero, out_valid
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked WIDTH-bit unsigned ALU with a registered 2*WIDTH-bit
// result and a zero flag.
// Build option ALU_SEQ_MUL_EN: when defined, MUL runs as a shift-add loop
// producing one partial product per cycle (latency WIDTH). When undefined,
// MUL is a single-cycle product like every other opcode.
//
// state  | meaning
// IDLE   | no result held, ready for operands
// MUL    | iterative multiply in progress (ALU_SEQ_MUL_EN only)
// DONE   | result valid on out/zero, waiting for out_ready
module alu_pipe #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    localparam int OW = 2 * WIDTH;
    localparam logic [OW-1:0] SUB_MASK = (OW'(1) << (WIDTH + 1)) - OW'(1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_MAX = 3'd6;
    localparam logic [2:0] OP_MIN = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   out_q;
    logic            zero_q;
    logic [OW-1:0]   a_ext, b_ext, alu_res;
    logic            in_ready_c, accept, load_res;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [OW-1:0]    mul_a_q;
    logic [WIDTH-1:0] mul_b_q;
    logic [OW-1:0]    acc_q, acc_sum;
    logic [CW-1:0]    cnt_q;
    logic             load_mul, finish_mul;

    assign acc_sum = acc_q + (mul_b_q[0] ? mul_a_q : '0);
`endif

    assign a_ext         = OW'(bus.A);
    assign b_ext         = OW'(bus.B);
    assign in_ready_c    = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign accept        = bus.in_valid && in_ready_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out       = out_q;
    assign bus.zero      = zero_q;

    // Single-cycle result for every opcode (MUL only when not iterative).
    always_comb begin
        alu_res = '0;
        case (bus.op)
            OP_ADD:  alu_res = a_ext + b_ext;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:  alu_res = '0;
`else
            OP_MUL:  alu_res = a_ext * b_ext;
`endif
            OP_OR:   alu_res = a_ext | b_ext;
            OP_AND:  alu_res = a_ext & b_ext;
            OP_SUB:  alu_res = (a_ext - b_ext) & SUB_MASK;
            OP_XOR:  alu_res = a_ext ^ b_ext;
            OP_MAX:  alu_res = (bus.A > bus.B) ? a_ext : b_ext;
            OP_MIN:  alu_res = (bus.A < bus.B) ? a_ext : b_ext;
            default: alu_res = '0;
        endcase
    end

    // Next-state logic and load strobes for the result/multiply registers.
    always_comb begin
        state_d  = state_q;
        load_res = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        load_mul   = 1'b0;
        finish_mul = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if ((state_q == S_DONE) && bus.out_ready) begin
                    state_d = S_IDLE;
                end
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    if (bus.op == OP_MUL) begin
                        state_d  = S_MUL;
                        load_mul = 1'b1;
                    end else begin
                        state_d  = S_DONE;
                        load_res = 1'b1;
                    end
`else
                    state_d  = S_DONE;
                    load_res = 1'b1;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                if (cnt_q == CW'(1)) begin
                    state_d    = S_DONE;
                    finish_mul = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State register and registered result/zero flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_res) begin
                out_q  <= alu_res;
                zero_q <= (alu_res == '0);
            end
`ifdef ALU_SEQ_MUL_EN
            else if (finish_mul) begin
                out_q  <= acc_sum;
                zero_q <= (acc_sum == '0);
            end
`endif
        end
    end

`ifdef ALU_SEQ_MUL_EN
    // Shift-add multiplier: A shifts left, B shifts right, one bit per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (load_mul) begin
            mul_a_q <= a_ext;
            mul_b_q <= bus.B;
            acc_q   <= '0;
            cnt_q   <= CW'(WIDTH);
        end else if (state_q == S_MUL) begin
            acc_q   <= acc_sum;
            mul_a_q <= mul_a_q << 1;
            mul_b_q <= mul_b_q >> 1;
            cnt_q   <= cnt_q - CW'(1);
        end
    end
`endif
endmodule
